// File: rtl/crash_manager_pkg.sv
// Shared game definitions: crash FSM state encoding and geometry shared with the collision detector.
package crash_manager_pkg;

  localparam int unsigned LIVES_MAX  = 3;
  localparam int unsigned LIVES_W    = 2;
  localparam int unsigned CAR_WIDTH  = 16;
  localparam int unsigned CAR_HEIGHT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CRASH = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

endpackage

// File: rtl/crash_manager_frame_counter.sv
// Loadable frame down-counter; terminal_c flags the last frame (count == 1).
module crash_manager_frame_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             terminal_c
);

  logic [WIDTH-1:0] count;

  // Load has priority over counting; the counter parks at zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign terminal_c = (count == WIDTH'(1));

endmodule

// File: rtl/crash_manager.sv
// Per-player crash sequencing: life loss, blinking freeze, obstacle restart and game over.
module crash_manager
  import crash_manager_pkg::*;
#(
  parameter int unsigned LIVES         = 3,
  parameter int unsigned FREEZE_FRAMES = 120,
  parameter int unsigned BLINK_PERIOD  = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_tick,
  input  logic               colision,
  input  logic               start,
  output logic [LIVES_W-1:0] lives,
  output logic               freeze,
  output logic               car_visible,
  output logic               game_over,
  output logic               crash_pulse,
  output logic               restart_obstacles
);

  localparam int unsigned FREEZE_W = $clog2(FREEZE_FRAMES + 1);
  localparam int unsigned BLINK_W  = $clog2(BLINK_PERIOD + 1);

  state_t state;

  logic run_hit_c;
  logic crash_load_c;
  logic crash_tick_c;
  logic freeze_tc_c;
  logic blink_tc_c;
  logic blink_load_c;

  assign run_hit_c    = (state == ST_RUN) && frame_tick && colision;
  assign crash_load_c = run_hit_c && (lives != LIVES_W'(1));
  assign crash_tick_c = (state == ST_CRASH) && frame_tick;
  // Blink counter restarts on crash entry and on every completed blink period.
  assign blink_load_c = crash_load_c || (crash_tick_c && blink_tc_c);

  crash_manager_frame_counter #(.WIDTH(FREEZE_W)) u_freeze_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (crash_load_c),
    .load_value (FREEZE_W'(FREEZE_FRAMES)),
    .enable     (crash_tick_c),
    .terminal_c (freeze_tc_c)
  );

  crash_manager_frame_counter #(.WIDTH(BLINK_W)) u_blink_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (blink_load_c),
    .load_value (BLINK_W'(BLINK_PERIOD)),
    .enable     (crash_tick_c),
    .terminal_c (blink_tc_c)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state             <= ST_IDLE;
      lives             <= LIVES_W'(LIVES);
      freeze            <= 1'b1;
      car_visible       <= 1'b1;
      game_over         <= 1'b0;
      crash_pulse       <= 1'b0;
      restart_obstacles <= 1'b0;
    end else begin
      crash_pulse       <= 1'b0;
      restart_obstacles <= 1'b0;
      case (state)
        ST_IDLE: begin
          freeze      <= 1'b1;
          car_visible <= 1'b1;
          if (start) begin
            state             <= ST_RUN;
            lives             <= LIVES_W'(LIVES);
            freeze            <= 1'b0;
            restart_obstacles <= 1'b1;
          end
        end
        ST_RUN: begin
          freeze <= 1'b0;
          if (run_hit_c) begin
            crash_pulse <= 1'b1;
            freeze      <= 1'b1;
            if (lives <= LIVES_W'(1)) begin
              state       <= ST_OVER;
              lives       <= '0;
              game_over   <= 1'b1;
              car_visible <= 1'b1;
            end else begin
              state       <= ST_CRASH;
              lives       <= lives - LIVES_W'(1);
              car_visible <= 1'b0;
            end
          end
        end
        ST_CRASH: begin
          if (frame_tick) begin
            if (freeze_tc_c) begin
              state             <= ST_RUN;
              freeze            <= 1'b0;
              car_visible       <= 1'b1;
              restart_obstacles <= 1'b1;
            end else if (blink_tc_c) begin
              car_visible <= ~car_visible;
            end
          end
        end
        ST_OVER: begin
          freeze      <= 1'b1;
          game_over   <= 1'b1;
          car_visible <= 1'b1;
          if (start) begin
            state             <= ST_RUN;
            lives             <= LIVES_W'(LIVES);
            game_over         <= 1'b0;
            freeze            <= 1'b0;
            restart_obstacles <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crash_manager.sv
// Directed bench for crash_manager with a short freeze (4 frames) and blink period (2 frames).
module tb_crash_manager;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       frame_tick;
  logic       colision;
  logic       start;
  logic [1:0] lives;
  logic       freeze;
  logic       car_visible;
  logic       game_over;
  logic       crash_pulse;
  logic       restart_obstacles;

  int checks = 0;
  int failures = 0;

  crash_manager #(
    .LIVES         (3),
    .FREEZE_FRAMES (4),
    .BLINK_PERIOD  (2)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .frame_tick        (frame_tick),
    .colision          (colision),
    .start             (start),
    .lives             (lives),
    .freeze            (freeze),
    .car_visible       (car_visible),
    .game_over         (game_over),
    .crash_pulse       (crash_pulse),
    .restart_obstacles (restart_obstacles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    frame_tick = 1'b0;
    colision   = 1'b0;
    start      = 1'b0;
    step();
    step();
    check("rst_lives", lives, 3);
    check("rst_freeze", freeze, 1);
    check("rst_game_over", game_over, 0);
    check("rst_car_visible", car_visible, 1);
    check("rst_restart", restart_obstacles, 0);
    reset_n = 1'b1;
    step();

    start = 1'b1;
    step();
    start = 1'b0;
    check("start_freeze", freeze, 0);
    check("start_restart", restart_obstacles, 1);
    check("start_lives", lives, 3);
    step();
    check("start_restart_once", restart_obstacles, 0);

    colision = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("no_tick_pulse", crash_pulse, 0);
    end
    check("no_tick_lives", lives, 3);
    check("no_tick_freeze", freeze, 0);

    tick_frame();
    check("crash1_pulse", crash_pulse, 1);
    check("crash1_lives", lives, 2);
    check("crash1_freeze", freeze, 1);
    check("crash1_visible", car_visible, 0);

    // Freeze sequence with colision held high: invulnerable, blinks every 2 frames.
    tick_frame();
    check("t1_pulse_single", crash_pulse, 0);
    check("t1_visible", car_visible, 0);
    check("t1_freeze", freeze, 1);
    tick_frame();
    check("t2_visible", car_visible, 1);
    tick_frame();
    check("t3_visible", car_visible, 1);
    check("t3_restart", restart_obstacles, 0);
    tick_frame();
    check("t4_freeze", freeze, 0);
    check("t4_visible", car_visible, 1);
    check("t4_restart", restart_obstacles, 1);
    check("t4_pulse", crash_pulse, 0);
    check("t4_lives", lives, 2);
    step();
    check("t4_restart_once", restart_obstacles, 0);
    check("t4_no_pulse", crash_pulse, 0);

    tick_frame();
    check("crash2_lives", lives, 1);
    for (int i = 0; i < 4; i++) tick_frame();
    check("crash2_back_run", freeze, 0);
    tick_frame();
    check("crash3_pulse", crash_pulse, 1);
    check("over_lives", lives, 0);
    check("over_game_over", game_over, 1);
    check("over_freeze", freeze, 1);
    check("over_visible", car_visible, 1);
    for (int i = 0; i < 3; i++) begin
      tick_frame();
      check("over_no_pulse", crash_pulse, 0);
      check("over_lives_hold", lives, 0);
    end

    start = 1'b1;
    frame_tick = 1'b1;
    step();
    start = 1'b0;
    frame_tick = 1'b0;
    check("restart_lives", lives, 3);
    check("restart_game_over", game_over, 0);
    check("restart_freeze", freeze, 0);
    check("restart_pulse", restart_obstacles, 1);
    check("restart_no_crash", crash_pulse, 0);

    tick_frame();
    check("crash4_lives", lives, 2);
    tick_frame();
    tick_frame();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("midrst_lives", lives, 3);
    check("midrst_freeze", freeze, 1);
    check("midrst_visible", car_visible, 1);
    check("midrst_restart", restart_obstacles, 0);
    check("midrst_game_over", game_over, 0);
    // Back in IDLE: collisions without start must not crash.
    tick_frame();
    check("idle_no_pulse", crash_pulse, 0);
    check("idle_freeze", freeze, 1);
    check("idle_lives", lives, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
